// File: rtl/aes_pkg.sv
// aes_pkg: shared AES decryption types, constants and byte-level transforms
package aes_pkg;
  localparam int AES_KW = 128;
  localparam int AES_NKEYS = 15;
  typedef enum logic [1:0] {AES128 = 2'b00, AES192 = 2'b01, AES256 = 2'b10, ILLEGAL = 2'b11} mode_e;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} seq_state_e;
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };
  function automatic logic [3:0] nr_of(input mode_e m);
    return m == AES256 ? 4'd14 : m == AES192 ? 4'd12 : 4'd10;
  endfunction
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = b;
    for (int i = 0; i < 4; i++) begin
      p = k[i] ? p ^ x : p;
      x = xt(x);
    end
    return p;
  endfunction
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
            gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
            gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
            gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
  endfunction
  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[32*c +: 32] = inv_mix_col(s[32*c +: 32]);
    return r;
  endfunction
  // Byte 4c+w is row w of column c, byte 0 in the top bits.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c-w+4)%4)+w) -: 8];
    return r;
  endfunction
  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = INV_SBOX[s[8*i +: 8]];
    return r;
  endfunction
endpackage

// File: rtl/aes_inv_rounddata.sv
// aes_inv_rounddata: one combinational inverse round; round 0 skips InvMixColumns, round Nr is key add only
module aes_inv_rounddata
  import aes_pkg::*;
(
  input  logic [3:0]        round,
  input  mode_e             mode,
  input  logic [AES_KW-1:0] round_key,
  input  logic [AES_KW-1:0] data_in,
  output logic [AES_KW-1:0] data_out
);
  logic [AES_KW-1:0] ark;
  logic [AES_KW-1:0] mixed;
  assign ark = data_in ^ round_key;
  assign mixed = round == 4'd0 ? ark : inv_mix_columns(ark);
  assign data_out = round == nr_of(mode) ? ark : inv_sub_bytes(inv_shift_rows(mixed));
endmodule

// File: rtl/aes_inv_round_seq.sv
// aes_inv_round_seq: iterative AES decryption sequencer reusing one aes_inv_rounddata stage
module aes_inv_round_seq #(
  parameter int KW = 128,
  parameter int NKEYS = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode,
  input  logic [KW-1:0] round_keys [NKEYS],
  input  logic [KW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [KW-1:0] out_data,
  output logic          out_err,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);
  import aes_pkg::*;
  seq_state_e st_q, st_d;
  mode_e mode_q, mode_d;
  logic [3:0] rd_q, rd_d;
  logic [KW-1:0] state_q, state_d;
  logic [KW-1:0] out_q, out_d;
  logic err_q, err_d;
  logic ov_q, ov_d;
  logic [3:0] nr;
  logic [3:0] kidx;
  logic [KW-1:0] rkey;
  logic [KW-1:0] rnd_out;
  assign nr = nr_of(mode_q);
  assign kidx = nr - rd_q;
  assign rkey = round_keys[kidx];
  aes_inv_rounddata u_round (
    .round    (rd_q),
    .mode     (mode_q),
    .round_key(rkey),
    .data_in  (state_q),
    .data_out (rnd_out)
  );
  always_comb begin
    st_d = st_q;
    mode_d = mode_q;
    rd_d = rd_q;
    state_d = state_q;
    out_d = out_q;
    err_d = err_q;
    ov_d = ov_q;
    case (st_q)
      IDLE: if (in_valid) begin
        state_d = in_data;
        mode_d = mode_e'(mode);
        rd_d = '0;
        st_d = mode == 2'b11 ? DONE : RUN;
        err_d = mode == 2'b11;
        ov_d = mode == 2'b11;
        out_d = mode == 2'b11 ? '0 : out_q;
      end
      RUN: begin
        state_d = rnd_out;
        rd_d = rd_q == nr ? rd_q : rd_q + 4'd1;
        out_d = rd_q == nr ? rnd_out : out_q;
        ov_d = rd_q == nr;
        st_d = rd_q == nr ? DONE : RUN;
      end
      DONE: if (out_ready) begin
        ov_d = 1'b0;
        err_d = 1'b0;
        st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
      mode_q <= AES128;
      rd_q <= '0;
      state_q <= '0;
      out_q <= '0;
      err_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      st_q <= st_d;
      mode_q <= mode_d;
      rd_q <= rd_d;
      state_q <= state_d;
      out_q <= out_d;
      err_q <= err_d;
      ov_q <= ov_d;
    end
  end
  assign in_ready = st_q == IDLE;
  assign busy = st_q != IDLE;
  assign out_data = out_q;
  assign out_err = err_q;
  assign out_valid = ov_q;
endmodule

// File: tb/tb_aes_inv_round_seq.sv
// tb_aes_inv_round_seq: randomized and vector checks against a textbook AES inverse cipher model
module tb_aes_inv_round_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] mode = 2'b00;
  logic [127:0] round_keys [15];
  logic [127:0] in_data = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [127:0] out_data;
  logic out_err;
  logic out_valid;
  logic out_ready = 1'b1;
  logic busy;
  int errors = 0;
  int checks = 0;
  logic [7:0] sb [256];
  logic [7:0] isb [256];

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] CT128 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] PT128 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PTF = 128'h00112233445566778899aabbccddeeff;

  aes_inv_round_seq dut (
    .clk(clk), .rst(rst), .mode(mode), .round_keys(round_keys),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_err(out_err), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [15:0] d;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++) if (gf(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      d = {inv, inv};
      s = inv ^ d[14:7] ^ d[13:6] ^ d[12:5] ^ d[11:4] ^ 8'h63;
      sb[x] = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key, input int m);
    int nk;
    int nr;
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc;
    nk = 4 + 2 * m;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = 0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (nk > 6 && i % nk == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 15; r++)
      round_keys[r] = r <= nr ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : {$urandom, $urandom, $urandom, $urandom};
  endtask

  function automatic logic [127:0] model_dec(input logic [127:0] ct, input int m);
    logic [7:0] s [16];
    logic [7:0] n [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] k;
    logic [127:0] res;
    int nr;
    nr = 10 + 2 * m;
    k = round_keys[nr];
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int r = nr - 1; r >= 0; r--) begin
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) n[4*c+w] = isb[s[4*((c-w+4)%4)+w]];
      k = round_keys[r];
      for (int i = 0; i < 16; i++) s[i] = n[i] ^ k[127-8*i -: 8];
      if (r > 0)
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gf(a0, 8'h0e) ^ gf(a1, 8'h0b) ^ gf(a2, 8'h0d) ^ gf(a3, 8'h09);
          s[4*c+1] = gf(a0, 8'h09) ^ gf(a1, 8'h0e) ^ gf(a2, 8'h0b) ^ gf(a3, 8'h0d);
          s[4*c+2] = gf(a0, 8'h0d) ^ gf(a1, 8'h09) ^ gf(a2, 8'h0e) ^ gf(a3, 8'h0b);
          s[4*c+3] = gf(a0, 8'h0b) ^ gf(a1, 8'h0d) ^ gf(a2, 8'h09) ^ gf(a3, 8'h0e);
        end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Present one block for exactly one edge, then scramble inputs that must be ignored.
  task automatic send(input logic [127:0] ct, input logic [1:0] m);
    in_data = ct;
    mode = m;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data = {$urandom, $urandom, $urandom, $urandom};
    mode = 2'($urandom);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b out_err=%b busy=%b want 1 0 0 0", in_ready, out_valid, out_err, busy);
    end
    checks++;
    if (out_data !== 128'h0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", out_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_aes128_vector();
    expand(K128, 0);
    out_ready = 1'b1;
    send(CT128, 2'b00);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL run_flags: busy=%b in_ready=%b want 1 0", busy, in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (dut.state_q !== 128'hbb36c7eb88334d49a4e7112e74f182c4) begin
      errors++;
      $display("FAIL state_r1: got %h want bb36c7eb88334d49a4e7112e74f182c4", dut.state_q);
    end
    @(posedge clk); #1;
    checks++;
    if (dut.state_q !== 128'h41d7c6537d669140dd2f179d02acc51b) begin
      errors++;
      $display("FAIL state_r2: got %h want 41d7c6537d669140dd2f179d02acc51b", dut.state_q);
    end
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (dut.state_q !== 128'h40bfabf406ee4d3042ca6b997a5c5816 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL state_r10: got %h valid=%b want 40bfabf406ee4d3042ca6b997a5c5816 valid=0", dut.state_q, out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== PT128 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL aes128_out: valid=%b err=%b data=%h want 1 0 %h", out_valid, out_err, out_data, PT128);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL aes128_release: valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    send(CT128, 2'b00);
    wait_out(lat);
    checks++;
    if (lat != 11 || out_data !== PT128) begin
      errors++;
      $display("FAIL bp_first: lat=%0d data=%h want 11 %h", lat, out_data, PT128);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_data !== PT128 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: data=%h in_ready=%b valid=%b want %h 0 1", i, out_data, in_ready, out_valid, PT128);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b valid=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_illegal();
    int lat;
    out_ready = 1'b1;
    send({$urandom, $urandom, $urandom, $urandom}, 2'b11);
    wait_out(lat);
    checks++;
    if (lat != 0 || out_valid !== 1'b1 || out_err !== 1'b1 || out_data !== 128'h0) begin
      errors++;
      $display("FAIL illegal_out: lat=%0d valid=%b err=%b data=%h want 0 1 1 0", lat, out_valid, out_err, out_data);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || out_err !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL illegal_clear: valid=%b err=%b in_ready=%b want 0 0 1", out_valid, out_err, in_ready);
    end
    send(CT128, 2'b00);
    wait_out(lat);
    checks++;
    if (lat != 11 || out_data !== PT128 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL illegal_next: lat=%0d err=%b data=%h want 11 0 %h", lat, out_err, out_data, PT128);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat;
    logic seen;
    send(CT128, 2'b00);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_flags: in_ready=%b valid=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
    end
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midrst_stale: out_valid seen=%b want 0", seen);
    end
    send(CT128, 2'b00);
    wait_out(lat);
    checks++;
    if (lat != 11 || out_data !== PT128) begin
      errors++;
      $display("FAIL midrst_rerun: lat=%0d data=%h want 11 %h", lat, out_data, PT128);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [127:0] a, b, d;
    logic a_now, o_now;
    int cyc;
    int acc [$];
    int oh [$];
    logic [127:0] got [$];
    expand({$urandom, $urandom, $urandom, $urandom, 128'h0}, 0);
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b1;
    in_data = a;
    mode = 2'b00;
    in_valid = 1'b1;
    cyc = 0;
    while (got.size() < 2 && cyc < 100) begin
      a_now = in_valid && in_ready;
      o_now = out_valid && out_ready;
      d = out_data;
      @(posedge clk); #1;
      cyc++;
      if (a_now) begin
        acc.push_back(cyc);
        if (acc.size() == 1) in_data = b;
        else in_valid = 1'b0;
      end
      if (o_now) begin
        oh.push_back(cyc);
        got.push_back(d);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got.size() != 2 || acc.size() != 2) begin
      errors++;
      $display("FAIL b2b_count: outputs=%0d accepts=%0d want 2 2", got.size(), acc.size());
    end else begin
      checks++;
      if (got[0] !== model_dec(a, 0) || got[1] !== model_dec(b, 0)) begin
        errors++;
        $display("FAIL b2b_data: got %h %h want %h %h", got[0], got[1], model_dec(a, 0), model_dec(b, 0));
      end
      checks++;
      if (acc[1] != oh[0] + 1 || acc[1] - acc[0] != 13) begin
        errors++;
        $display("FAIL b2b_timing: accept2=%0d out1=%0d accept1=%0d want accept2=out1+1 and period 13", acc[1], oh[0], acc[0]);
      end
    end
  endtask

  task automatic test_fips_192_256();
    int lat;
    for (int m = 1; m <= 2; m++) begin
      expand(m == 1 ? K192 : K256, m);
      send(m == 1 ? CT192 : CT256, 2'(m));
      wait_out(lat);
      checks++;
      if (lat != 11 + 2 * m || out_data !== PTF || out_err !== 1'b0) begin
        errors++;
        $display("FAIL fips_mode%0d: lat=%0d err=%b data=%h want %0d 0 %h", m, lat, out_err, out_data, 11 + 2 * m, PTF);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    int lat;
    int m;
    logic [127:0] ct;
    for (int t = 0; t < 8; t++) begin
      m = $urandom_range(0, 2);
      expand({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, m);
      ct = {$urandom, $urandom, $urandom, $urandom};
      send(ct, 2'(m));
      wait_out(lat);
      checks++;
      if (lat != 11 + 2 * m || out_data !== model_dec(ct, m) || out_err !== 1'b0) begin
        errors++;
        $display("FAIL rand[%0d] mode%0d: lat=%0d data=%h want %0d %h", t, m, lat, out_data, 11 + 2 * m, model_dec(ct, m));
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int r = 0; r < 15; r++) round_keys[r] = '0;
    build_sbox();
    test_reset();
    test_aes128_vector();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    test_fips_192_256();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
